clk_monitor: RTL and testbench

Clock-activity and frequency monitor for the divided system clock. It runs in the 27 MHz `clk_in` domain and samples the slow divided clock (nominally 500 kHz, toggling every 27 input cycles) as an asynchronous input. It measures every half-period in `clk_in` cycles, flags half-periods outside tolerance, and detects a stopped clock. It drives the design-level `locked` indication that downstream logic uses to gate operation on the slow clock.

---
 rtl/clk_monitor.sv | 123 ++++++++++++
 tb/tb_clk_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Activity and frequency monitor for a slow clock sampled in the clk_in domain.
// Measures each half-period, checks it against a tolerance window, and tracks lock and timeout.
module clk_monitor #(
   parameter int EXP_HALF   = 27,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 108,
   parameter int CNT_W      = 8
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             mon_clk,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             in_range,
   output logic             locked,
   output logic             timeout
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] RANGE_LO = CNT_W'(EXP_HALF - TOL);
   localparam logic [CNT_W-1:0] RANGE_HI = CNT_W'(EXP_HALF + TOL);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
   localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;

   state_t           state, state_nxt;
   logic             s1, s2, s3;
   logic [CNT_W-1:0] cnt;
   logic [GW-1:0]    good, good_nxt;
   logic             timeout_nxt;
   logic             rise_det, fall_det, edge_det, cnt_sat, meas, meas_ok;

   assign rise_det = s2 & ~s3;
   assign fall_det = ~s2 & s3;
   assign edge_det = rise_det | fall_det;
   assign cnt_sat  = (cnt == CNT_SAT);
   assign meas     = edge_det && (state != IDLE);
   assign meas_ok  = (cnt >= RANGE_LO) && (cnt <= RANGE_HI);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state   <= IDLE;
         good    <= '0;
         timeout <= 1'b0;
         locked  <= 1'b0;
      end else begin
         state   <= state_nxt;
         good    <= good_nxt;
         timeout <= timeout_nxt;
         locked  <= (state_nxt == LOCK);
      end
   end

   // An edge always takes priority over the saturation-driven drop to IDLE.
   always_comb begin
      state_nxt   = state;
      good_nxt    = good;
      timeout_nxt = timeout;
      if (edge_det) begin
         timeout_nxt = 1'b0;
         case (state)
            IDLE: begin
               state_nxt = MEAS;
               good_nxt  = '0;
            end
            MEAS: begin
               if (meas_ok) begin
                  good_nxt = (good == GOOD_MAX) ? good : good + 1'b1;
                  if (good_nxt == GOOD_MAX) state_nxt = LOCK;
               end else begin
                  good_nxt = '0;
               end
            end
            LOCK: begin
               if (!meas_ok) begin
                  state_nxt = MEAS;
                  good_nxt  = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               good_nxt  = '0;
            end
         endcase
      end else if (cnt_sat) begin
         state_nxt   = IDLE;
         good_nxt    = '0;
         timeout_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
         cnt          <= '0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         half_period  <= '0;
         period_valid <= 1'b0;
         in_range     <= 1'b0;
      end else begin
         s1           <= mon_clk;
         s2           <= s1;
         s3           <= s2;
         rise_pulse   <= rise_det;
         fall_pulse   <= fall_det;
         period_valid <= meas;
         if (edge_det)     cnt <= CNT_W'(1);
         else if (!cnt_sat) cnt <= cnt + 1'b1;
         if (meas) begin
            half_period <= cnt;
            in_range    <= meas_ok;
         end
      end
   end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: expected measurements are queued by the stimulus
// process and checked by a monitor whenever period_valid fires.
module tb_clk_monitor;

   localparam int CNT_W = 8;
   localparam int W     = CNT_W + 2;

   logic             clk_in  = 1'b0;
   logic             reset   = 1'b1;
   logic             mon_clk = 1'b0;
   logic             rise_pulse, fall_pulse, period_valid, in_range, locked, timeout;
   logic [CNT_W-1:0] half_period;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_e;
   int n_checks = 0;
   int n_fail   = 0;

   clk_monitor #(
      .EXP_HALF(27), .TOL(2), .LOCK_COUNT(4), .TIMEOUT(108), .CNT_W(CNT_W)
   ) dut (
      .clk_in(clk_in), .reset(reset), .mon_clk(mon_clk),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .half_period(half_period), .period_valid(period_valid),
      .in_range(in_range), .locked(locked), .timeout(timeout)
   );

   // clock / watchdog
   always #5 clk_in = ~clk_in;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic expect_m(input int h, input logic ir, input logic lk);
      exp_q.push_back({CNT_W'(h), ir, lk});
   endtask

   task automatic drive_half(input logic lvl, input int h);
      mon_clk = lvl;
      repeat (h) @(posedge clk_in);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rise"},   rise_pulse,   0);
      check({tag, "_fall"},   fall_pulse,   0);
      check({tag, "_half"},   half_period,  0);
      check({tag, "_valid"},  period_valid, 0);
      check({tag, "_inr"},    in_range,     0);
      check({tag, "_locked"}, locked,       0);
      check({tag, "_tmo"},    timeout,      0);
   endtask

   // scoreboard monitor
   always @(negedge clk_in) begin
      if (!reset) begin
         if (rise_pulse | fall_pulse) check("pulse_excl", rise_pulse & fall_pulse, 0);
         if (period_valid) begin
            check("valid_with_pulse", rise_pulse | fall_pulse, 1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL meas_unexpected: got half_period %0d, required no period_valid",
                        half_period);
            end else begin
               exp_e = exp_q.pop_front();
               check("meas{half,inr,lock}", {half_period, in_range, locked}, exp_e);
            end
         end
      end
   end

   // stimulus
   int b_h  [12] = '{29, 25, 30, 27, 25, 29, 24, 27, 29, 25, 29, 27};
   int b_m  [12] = '{27, 29, 25, 30, 27, 25, 29, 24, 27, 29, 25, 29};
   bit b_ir [12] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};
   bit b_lk [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

   initial begin
      int k;
      int n;
      logic prev_locked;

      // reset values
      repeat (3) @(posedge clk_in);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      // ideal clock: reference edge, then lock on the 5th edge
      drive_half(1'b1, 27);
      for (int i = 0; i < 9; i++) begin
         expect_m(27, 1'b1, (i >= 3));
         drive_half((i % 2 == 0) ? 1'b0 : 1'b1, 27);
      end
      check("q_empty_ideal", exp_q.size(), 0);

      // tolerance boundaries while locked and while acquiring
      for (int i = 0; i < 12; i++) begin
         expect_m(b_m[i], b_ir[i], b_lk[i]);
         drive_half((i % 2 == 0) ? 1'b1 : 1'b0, b_h[i]);
      end
      check("locked_after_boundary", locked, 1);

      // stopped clock after lock
      expect_m(27, 1'b1, 1'b1);
      mon_clk = 1'b1;
      k = 0;
      do begin
         @(posedge clk_in);
         #1;
         k++;
      end while (!rise_pulse && k < 8);
      check("edge_latency", k, 3);
      n = 0;
      prev_locked = locked;
      do begin
         prev_locked = locked;
         @(posedge clk_in);
         #1;
         n++;
      end while (!timeout && n < 200);
      check("timeout_delay", n, 108);
      check("locked_before_timeout", prev_locked, 1);
      check("locked_at_timeout", locked, 0);
      repeat (10) @(posedge clk_in);
      #1;
      check("timeout_held", timeout, 1);
      check("q_empty_stopped", exp_q.size(), 0);

      // restart: reference edge clears timeout, relock after 4 edges
      drive_half(1'b0, 27);
      check("timeout_cleared", timeout, 0);
      check("q_empty_restart_ref", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) begin
         expect_m(27, 1'b1, (i == 3));
         drive_half((i % 2 == 0) ? 1'b1 : 1'b0, 27);
      end
      check("relocked", locked, 1);

      // reset while locked, then reacquire
      expect_m(27, 1'b1, 1'b1);
      drive_half(1'b1, 27);
      reset = 1'b1;
      @(posedge clk_in);
      #1;
      check_all_zero("midreset");
      reset = 1'b0;
      drive_half(1'b1, 27);
      for (int i = 0; i < 4; i++) begin
         expect_m(27, 1'b1, (i == 3));
         drive_half((i % 2 == 0) ? 1'b0 : 1'b1, 27);
      end
      check("q_empty_reacquire", exp_q.size(), 0);

      // edge in the same cycle the counter saturates
      expect_m(27, 1'b1, 1'b1);
      drive_half(1'b0, 108);
      check("no_timeout_108_mid", timeout, 0);
      expect_m(108, 1'b0, 1'b0);
      drive_half(1'b1, 27);
      check("no_timeout_108", timeout, 0);

      // asymmetric duty: high 20, low 34
      expect_m(27, 1'b1, 1'b0);
      drive_half(1'b0, 34);
      for (int i = 0; i < 6; i++) begin
         expect_m((i % 2 == 0) ? 34 : 20, 1'b0, 1'b0);
         drive_half((i % 2 == 0) ? 1'b1 : 1'b0, (i % 2 == 0) ? 20 : 34);
      end
      check("asym_unlocked", locked, 0);

      repeat (5) @(posedge clk_in);
      #1;
      check("q_empty_final", exp_q.size(), 0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
